io_bus_arbiter: RTL and testbench
=================================

// Module: io_bus_arbiter
// PURPOSE
//  Shares the single IO_bus master port between NUM_REQ on-chip requesters (e.g. command
//  decoder, trajectory sequencer). Round-robin arbitration; runs the 4-phase
//  handshake_1/handshake_2 transfer on the bus and returns read data or a timeout error.
//  Sits between the requesters and the IO_bus fan-out to the motor/encoder/PWM subsystems.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  TIMEOUT   255  max cycles waiting on any handshake_2 edge before abort (1..65535)
// PORTS
//  clk        in   1           system clock, all logic rising-edge
//  reset      in   1           asynchronous, active-low reset
//  req        in   NUM_REQ     request, held high until matching done
//  req_addr   in   NUM_REQ*8   per-requester reg_address (packed, requester i at [8i+:8])
//  req_rw     in   NUM_REQ     1 = read, 0 = write
//  req_wdata  in   NUM_REQ*32  per-requester write data
//  grant      out  NUM_REQ     one-hot, high for whole transfer of granted requester
//  done       out  NUM_REQ     one-cycle pulse at transfer end to granted requester
//  err        out  1           valid with done: 1 = handshake timeout
//  rdata      out  32          read data, valid with done (read, err=0)
//  bus        IO_bus.master    data_out, reg_address, RW, handshake_1 out; data_in, handshake_2 in
// BEHAVIOUR
//  Reset: grant=0, done=0, err=0, rdata=0, handshake_1=0, RW=0, reg_address=0, data_out=0,
//   rr pointer=NUM_REQ-1 (so requester 0 wins first), state=IDLE, timer=0.
//  All outputs registered. handshake_2 is same-clock; no synchroniser.
//  FSM: IDLE -> REQ -> ACK -> DONE -> IDLE; any timeout -> ABORT -> IDLE.
//  IDLE: if any req, pick first set bit searching from rr+1 modulo NUM_REQ; next edge: grant
//   one-hot, latch addr/rw/wdata onto bus, handshake_1=1, rr=winner, timer=0, go REQ.
//   No req: stay, all bus outputs hold last values, handshake_1=0.
//  REQ: wait handshake_2=1. On it: latch data_in into rdata if RW=1, handshake_1=0, timer=0, go ACK.
//  ACK: wait handshake_2=0. On it: go DONE.
//  DONE: one cycle; done[winner]=1, err=0; grant cleared same edge leaving DONE; go IDLE.
//  Timer: increments each cycle in REQ/ACK; reaching TIMEOUT -> ABORT: handshake_1=0,
//   done[winner]=1, err=1, rdata unchanged; then IDLE. Slave left unsynchronised is not chased.
//  Latency: req rises at edge 0 -> handshake_1 at edge 1; zero-wait slave (h2 next cycle)
//   -> done pulse at edge 5. Back-to-back: next grant earliest one cycle after done.
//  Requester dropping req mid-transfer is ignored; transfer completes, done still pulsed.
//  Inputs of granted requester sampled only at grant; later changes have no effect.
//  Simultaneous reqs: strict round-robin, no starvation; worst-case wait NUM_REQ-1 transfers.
//  handshake_2 already high in IDLE: ignored; REQ still requires h2 high after handshake_1 set.
//  Reset mid-transfer: immediate return to reset values; handshake_1 drops asynchronously.
//  Timer width $clog2(TIMEOUT+1); no wrap possible (abort precedes overflow).
// STRUCTURE
//  Shared package (global_constants.sv): state enum io_arb_state_t {IDLE,REQ,ACK,DONE,ABORT},
//   IO_ADDR_W=8, IO_DATA_W=32.
//  One sub-module: rr_arbiter (NUM_REQ req + last pointer -> one-hot winner + index, combinational);
//   FSM, timer and bus registers in top.
// TESTING
//  1 Single write: req[0], addr 8'h12, wdata 32'hDEADBEEF, slave h2 1 cycle later -> bus shows
//   values with handshake_1; done[0] at edge 5, err=0.
//  2 Single read: req[2] rw=1 addr 8'h40, slave data_in 32'h0000_1234 -> rdata=32'h1234 with done[2].
//  3 All 4 req held high continuously -> grant order 0,1,2,3,0,... each granted exactly once per round.
//  4 Slave never asserts h2, TIMEOUT=255 -> handshake_1 drops after 255 cycles in REQ; done+err=1.
//  5 Slave holds h2 high forever after ack -> ACK timeout, err=1; next request still serviced.
//  6 reset low mid-REQ -> handshake_1=0, grant=0 immediately; after release req[1] pending -> served first.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// Shared constants and types for the IO_bus arbiter.
// Holds the bus widths, the FSM state encoding and the latched transfer payload.
package io_bus_arbiter_pkg;

   localparam int unsigned IO_ADDR_W = 8;
   localparam int unsigned IO_DATA_W = 32;

   typedef logic [2:0] io_arb_state_t;

   localparam io_arb_state_t IDLE  = 3'd0;
   localparam io_arb_state_t REQ   = 3'd1;
   localparam io_arb_state_t ACK   = 3'd2;
   localparam io_arb_state_t DONE  = 3'd3;
   localparam io_arb_state_t ABORT = 3'd4;

   // Payload captured from the winning requester at grant time
   typedef struct packed {
      logic [IO_ADDR_W-1:0] addr;
      logic                 rw;
      logic [IO_DATA_W-1:0] wdata;
   } io_xfer_t;

endpackage

// File: rtl/IO_bus.sv
// IO_bus: single-master register bus with a 4-phase handshake_1/handshake_2 pair.
// The arbiter uses the master modport; motor/encoder/PWM subsystems sit on the slave side.
interface IO_bus;
   import io_bus_arbiter_pkg::*;

   logic [IO_DATA_W-1:0] data_out;
   logic [IO_DATA_W-1:0] data_in;
   logic [IO_ADDR_W-1:0] reg_address;
   logic                 RW;
   logic                 handshake_1;
   logic                 handshake_2;

   modport master (
      output data_out,
      output reg_address,
      output RW,
      output handshake_1,
      input  data_in,
      input  handshake_2
   );

   modport slave (
      input  data_out,
      input  reg_address,
      input  RW,
      input  handshake_1,
      output data_in,
      output handshake_2
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from last+1, wrapping.
// Produces the one-hot winner, its index and a valid flag.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic [NUM_REQ-1:0]         winner,
   output logic [$clog2(NUM_REQ)-1:0] index,
   output logic                       valid
);

   localparam int unsigned PW = $clog2(NUM_REQ);

   logic [PW-1:0] cand;

   // Offset 1..NUM_REQ from last; offset NUM_REQ lands back on last itself
   always_comb begin
      winner = '0;
      index  = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = PW'((32'(last) + i) % NUM_REQ);
         if (!valid && req[cand]) begin
            valid        = 1'b1;
            index        = cand;
            winner[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO_bus master port between NUM_REQ requesters.
// Runs the 4-phase handshake per transfer and reports completion or a handshake timeout.
module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*IO_ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ-1:0]             req_rw,
   input  logic [NUM_REQ*IO_DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             done,
   output logic                           err,
   output logic [IO_DATA_W-1:0]           rdata,
   IO_bus.master                          bus
);

   localparam int unsigned PW = $clog2(NUM_REQ);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   io_arb_state_t        state, state_nxt;
   logic [TW-1:0]        timer, timer_nxt;
   logic [PW-1:0]        rr, rr_nxt;
   logic [NUM_REQ-1:0]   grant_nxt, done_nxt;
   logic                 err_nxt;
   logic [IO_DATA_W-1:0] rdata_nxt;
   logic                 h1, h1_nxt;
   io_xfer_t             xfer, xfer_nxt, sel_xfer;

   logic [NUM_REQ-1:0]   win_onehot;
   logic [PW-1:0]        win_idx;
   logic                 win_valid;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req    (req),
      .last   (rr),
      .winner (win_onehot),
      .index  (win_idx),
      .valid  (win_valid)
   );

   // Mux the winning requester's payload out of the packed input buses
   always_comb begin
      sel_xfer = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (win_onehot[i]) begin
            sel_xfer.addr  = req_addr[i*IO_ADDR_W +: IO_ADDR_W];
            sel_xfer.rw    = req_rw[i];
            sel_xfer.wdata = req_wdata[i*IO_DATA_W +: IO_DATA_W];
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      rr_nxt    = rr;
      grant_nxt = grant;
      done_nxt  = '0;
      err_nxt   = 1'b0;
      rdata_nxt = rdata;
      h1_nxt    = h1;
      xfer_nxt  = xfer;

      case (state)
         IDLE: begin
            h1_nxt = 1'b0;
            if (win_valid) begin
               grant_nxt = win_onehot;
               xfer_nxt  = sel_xfer;
               h1_nxt    = 1'b1;
               rr_nxt    = win_idx;
               timer_nxt = '0;
               state_nxt = REQ;
            end
         end

         REQ: begin
            if (bus.handshake_2) begin
               if (xfer.rw) begin
                  rdata_nxt = bus.data_in;
               end
               h1_nxt    = 1'b0;
               timer_nxt = '0;
               state_nxt = ACK;
            end else if (timer == TIMER_LAST) begin
               h1_nxt    = 1'b0;
               done_nxt  = grant;
               err_nxt   = 1'b1;
               timer_nxt = '0;
               state_nxt = ABORT;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end

         ACK: begin
            if (!bus.handshake_2) begin
               done_nxt  = grant;
               timer_nxt = '0;
               state_nxt = DONE;
            end else if (timer == TIMER_LAST) begin
               done_nxt  = grant;
               err_nxt   = 1'b1;
               timer_nxt = '0;
               state_nxt = ABORT;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end

         DONE, ABORT: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end

         default: begin
            grant_nxt = '0;
            h1_nxt    = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops handshake_1 and grant immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         timer <= '0;
         rr    <= PW'(NUM_REQ - 1);
         grant <= '0;
         done  <= '0;
         err   <= 1'b0;
         rdata <= '0;
         h1    <= 1'b0;
         xfer  <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         rr    <= rr_nxt;
         grant <= grant_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
         rdata <= rdata_nxt;
         h1    <= h1_nxt;
         xfer  <= xfer_nxt;
      end
   end

   assign bus.handshake_1 = h1;
   assign bus.reg_address = xfer.addr;
   assign bus.RW          = xfer.rw;
   assign bus.data_out    = xfer.wdata;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: single write/read, round-robin order, REQ/ACK timeouts
// and asynchronous reset mid-transfer, against a registered slave model.
module tb_io_bus_arbiter;
   import io_bus_arbiter_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned TO = 255;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [N-1:0]             req;
   logic [N*IO_ADDR_W-1:0]   req_addr;
   logic [N-1:0]             req_rw;
   logic [N*IO_DATA_W-1:0]   req_wdata;
   logic [N-1:0]             grant;
   logic [N-1:0]             done;
   logic                     err;
   logic [IO_DATA_W-1:0]     rdata;

   IO_bus bus_i ();

   io_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_addr  (req_addr),
      .req_rw    (req_rw),
      .req_wdata (req_wdata),
      .grant     (grant),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .bus       (bus_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int slave_mode = 0;   // 0 = follows handshake_1 one cycle later, 1 = never acks, 2 = sticks high
   logic h1_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Slave: registers handshake_1 and answers on handshake_2 the following cycle
   initial begin
      bus_i.handshake_2 = 1'b0;
      forever begin
         @(negedge clk);
         h1_seen = bus_i.handshake_1;
         @(posedge clk);
         #2;
         case (slave_mode)
            0:       bus_i.handshake_2 = h1_seen;
            1:       bus_i.handshake_2 = 1'b0;
            default: bus_i.handshake_2 = bus_i.handshake_2 | h1_seen;
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic set_req(input int idx, input logic rw, input logic [7:0] a, input logic [31:0] wd);
      req_rw[idx]            = rw;
      req_addr[idx*8 +: 8]   = a;
      req_wdata[idx*32 +: 32] = wd;
      req[idx]               = 1'b1;
   endtask

   task automatic wait_done(input int limit);
      for (int k = 0; k < limit && done == '0; k++) tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'h0);
      chk({tag, "_done"},  32'(done),  32'h0);
      chk({tag, "_err"},   32'(err),   32'h0);
      chk({tag, "_rdata"}, rdata,      32'h0);
      chk({tag, "_h1"},    32'(bus_i.handshake_1), 32'h0);
      chk({tag, "_rw"},    32'(bus_i.RW),          32'h0);
      chk({tag, "_addr"},  32'(bus_i.reg_address), 32'h0);
      chk({tag, "_dout"},  bus_i.data_out,         32'h0);
   endtask

   // Full transfer against the normal slave, request issued while the arbiter is idle
   task automatic xfer(input int idx, input logic rw, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] sd);
      bus_i.data_in = sd;
      set_req(idx, rw, a, wd);
      tick();
      chk("x_grant", 32'(grant), 32'h1 << idx);
      chk("x_h1",    32'(bus_i.handshake_1), 32'h1);
      chk("x_addr",  32'(bus_i.reg_address), 32'(a));
      chk("x_rw",    32'(bus_i.RW), 32'(rw));
      if (!rw) chk("x_dout", bus_i.data_out, wd);
      wait_done(600);
      chk("x_done", 32'(done), 32'h1 << idx);
      chk("x_err",  32'(err), 32'h0);
      if (rw) chk("x_rdata", rdata, sd);
      req[idx] = 1'b0;
      tick();
      chk("x_done_clr",  32'(done),  32'h0);
      chk("x_grant_clr", 32'(grant), 32'h0);
   endtask

   initial begin
      reset         = 1'b0;
      req           = '0;
      req_addr      = '0;
      req_rw        = '0;
      req_wdata     = '0;
      bus_i.data_in = '0;
      ticks(3);
      chk_reset_vals("rst0");
      reset = 1'b1;

      // 1: single write, cycle-exact latency; this tick is edge 0
      tick();
      bus_i.data_in = 32'h0;
      set_req(0, 1'b0, 8'h12, 32'hDEADBEEF);
      tick();                                   // edge 1
      chk("w_grant", 32'(grant), 32'h1);
      chk("w_h1",    32'(bus_i.handshake_1), 32'h1);
      chk("w_addr",  32'(bus_i.reg_address), 32'h12);
      chk("w_dout",  bus_i.data_out, 32'hDEADBEEF);
      chk("w_rw",    32'(bus_i.RW), 32'h0);
      ticks(3);                                 // edge 4
      chk("w_done_e4", 32'(done), 32'h0);
      tick();                                   // edge 5
      chk("w_done_e5", 32'(done), 32'h1);
      chk("w_err",     32'(err),  32'h0);
      chk("w_grant_e5", 32'(grant), 32'h1);
      req[0] = 1'b0;
      tick();                                   // edge 6
      chk("w_done_e6",  32'(done),  32'h0);
      chk("w_grant_e6", 32'(grant), 32'h0);

      // 2: single read from requester 2
      xfer(2, 1'b1, 8'h40, 32'h0, 32'h0000_1234);

      // 3: all four held high from reset -> strict 0,1,2,3,0,... order
      reset = 1'b0;
      tick();
      chk_reset_vals("rst1");
      reset = 1'b1;
      bus_i.data_in = 32'h0000_CAFE;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h80 + i), 32'h0);
      for (int k = 0; k < 8; k++) begin
         tick();
         wait_done(600);
         chk("rr_done",  32'(done),  32'h1 << (k % 4));
         chk("rr_grant", 32'(grant), 32'h1 << (k % 4));
      end
      chk("rr_rdata", rdata, 32'h0000_CAFE);
      req = '0;
      ticks(3);

      // 4: slave never answers -> abort after 255 cycles in REQ, rdata untouched
      slave_mode    = 1;
      bus_i.data_in = 32'hFFFF_FFFF;
      set_req(1, 1'b1, 8'h55, 32'h0);
      tick();                                   // edge 1
      chk("tr_grant", 32'(grant), 32'h2);
      ticks(254);                               // edge 255
      chk("tr_h1_255",   32'(bus_i.handshake_1), 32'h1);
      chk("tr_done_255", 32'(done), 32'h0);
      tick();                                   // edge 256
      chk("tr_h1_256", 32'(bus_i.handshake_1), 32'h0);
      chk("tr_done",   32'(done), 32'h2);
      chk("tr_err",    32'(err),  32'h1);
      chk("tr_rdata",  rdata, 32'h0000_CAFE);
      req[1] = 1'b0;
      tick();
      chk("tr_done_clr", 32'(done),  32'h0);
      chk("tr_err_clr",  32'(err),   32'h0);
      chk("tr_grant_clr", 32'(grant), 32'h0);

      // 5: slave holds handshake_2 high -> ACK timeout, then a normal transfer
      slave_mode = 2;
      set_req(3, 1'b0, 8'hA0, 32'h1111_2222);
      tick();                                   // edge 1
      chk("ta_grant", 32'(grant), 32'h8);
      ticks(256);                               // edge 257
      chk("ta_h1",       32'(bus_i.handshake_1), 32'h0);
      chk("ta_done_257", 32'(done), 32'h0);
      tick();                                   // edge 258
      chk("ta_done", 32'(done), 32'h8);
      chk("ta_err",  32'(err),  32'h1);
      req[3]     = 1'b0;
      slave_mode = 0;
      tick();
      chk("ta_grant_clr", 32'(grant), 32'h0);
      xfer(0, 1'b0, 8'h21, 32'h0BAD_F00D, 32'h0);

      // 6: reset mid-REQ clears outputs at once; pending req[1] served first afterwards
      slave_mode = 1;
      set_req(0, 1'b0, 8'h33, 32'h7777_8888);
      tick();
      chk("rs_grant", 32'(grant), 32'h1);
      ticks(3);
      reset  = 1'b0;
      req[0] = 1'b0;
      set_req(1, 1'b0, 8'h66, 32'h5555_AAAA);
      #1;
      chk_reset_vals("rs_async");
      slave_mode = 0;
      tick();
      reset = 1'b1;
      tick();
      chk("rs_first_grant", 32'(grant), 32'h2);
      chk("rs_addr", 32'(bus_i.reg_address), 32'h66);
      wait_done(600);
      chk("rs_done", 32'(done), 32'h2);
      chk("rs_err",  32'(err),  32'h0);
      req[1] = 1'b0;
      ticks(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
